// File: rtl/ldb_ur_loader.sv
// ldb_ur_loader: packs IN_W-bit beats into DATA_W-bit words and writes them to the UR RAM.
// Optional abort input enabled by LDB_LOADER_ABORT_EN.
module ldb_ur_loader #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 128,
   parameter int IN_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [ADDR_W:0]   cmd_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_data,
`ifdef LDB_LOADER_ABORT_EN
   input  logic              abort,
`endif
   output logic              ur_we,
   output logic [ADDR_W-1:0] ur_addr,
   output logic [DATA_W-1:0] ur_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int BPW = DATA_W / IN_W;
   localparam int BW  = BPW > 1 ? $clog2(BPW) : 1;
   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, FIN = 2'd2;
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
   logic [1:0]        state_q, state_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [ADDR_W-1:0] addr_q, addr_d, ur_addr_q, ur_addr_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [DATA_W-1:0] pack_q, pack_d, ur_wdata_q, ur_wdata_d, packed_w;
   logic              err_q, err_d, we_q, we_d;
   logic              abort_w, beat_acc, word_end;
`ifdef LDB_LOADER_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif
   assign beat_acc  = state_q == LOAD && in_valid && !abort_w;
   assign word_end  = beat_acc && beat_q == BW'(BPW - 1);
   assign cmd_ready = state_q == IDLE;
   assign in_ready  = state_q == LOAD;
   assign busy      = state_q != IDLE;
   assign done      = state_q == FIN;
   assign err       = done && err_q;
   assign ur_we     = we_q;
   assign ur_addr   = ur_addr_q;
   assign ur_wdata  = ur_wdata_q;
   always_comb begin
      packed_w = pack_q;
      packed_w[int'(beat_q) * IN_W +: IN_W] = in_data;
   end
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      pack_d     = pack_q;
      err_d      = err_q;
      we_d       = 1'b0;
      ur_addr_d  = ur_addr_q;
      ur_wdata_d = ur_wdata_q;
      if (state_q == IDLE && cmd_valid) begin
         addr_d  = cmd_base;
         rem_d   = cmd_len;
         err_d   = cmd_len > DEPTH;
         state_d = (cmd_len == '0 || cmd_len > DEPTH) ? FIN : LOAD;
      end else if (state_q == LOAD && abort_w) begin
         state_d = FIN;
         err_d   = 1'b1;
         beat_d  = '0;
         pack_d  = '0;
      end else if (beat_acc) begin
         beat_d = word_end ? '0 : beat_q + 1'b1;
         pack_d = packed_w;
         if (word_end) begin
            we_d       = 1'b1;
            ur_addr_d  = addr_q;
            ur_wdata_d = packed_w;
            addr_d     = addr_q + 1'b1;
            rem_d      = rem_q - 1'b1;
            state_d    = rem_q == ONE ? FIN : LOAD;
         end
      end else if (state_q != LOAD) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         addr_q     <= '0;
         rem_q      <= '0;
         pack_q     <= '0;
         err_q      <= 1'b0;
         we_q       <= 1'b0;
         ur_addr_q  <= '0;
         ur_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         pack_q     <= pack_d;
         err_q      <= err_d;
         we_q       <= we_d;
         ur_addr_q  <= ur_addr_d;
         ur_wdata_q <= ur_wdata_d;
      end
   end
endmodule

// File: tb/tb_ldb_ur_loader.sv
// tb_ldb_ur_loader: directed scoreboard bench for ldb_ur_loader (abort steps under LDB_LOADER_ABORT_EN).
module tb_ldb_ur_loader;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0, cmd_ready;
   logic [10:0]  cmd_base = '0;
   logic [11:0]  cmd_len = '0;
   logic         in_valid = 1'b0, in_ready;
   logic [31:0]  in_data = '0;
   logic         abort = 1'b0;
   logic         ur_we, busy, done, err;
   logic [10:0]  ur_addr;
   logic [127:0] ur_wdata;
   int           vectors = 0, miscompares = 0;
   int           writes = 0, dones = 0, accepts = 0, cyc = 0;
   int           w0, d0, a0, i0;
   logic         done_we, done_err;
   logic [10:0]  ea[$];
   logic [127:0] ed[$];
   int           wcyc[$];

   ldb_ur_loader dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef LDB_LOADER_ABORT_EN
      .abort(abort),
`endif
      .ur_we(ur_we), .ur_addr(ur_addr), .ur_wdata(ur_wdata),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every ur_we must match the next expected word in the scoreboard.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (ur_we) begin
            writes++;
            wcyc.push_back(cyc);
            chk("write_expected", ea.size() > 0, 1);
            if (ea.size() > 0) begin
               chk("ur_addr", ur_addr, ea.pop_front());
               chk("ur_wdata", ur_wdata, ed.pop_front());
            end
         end
         if (done) begin
            dones++;
            done_we  = ur_we;
            done_err = err;
         end
         if (err) chk("err_with_done", done, 1);
         if (cmd_valid && cmd_ready) accepts++;
      end
   end

   task automatic send_cmd(input logic [10:0] b, input logic [11:0] l);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_base  = b;
      cmd_len   = l;
      while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
      chk("cmd_timeout", n < 200, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // mode 0: fixed 0x11111111*(k+1) pattern, 1: random continuous, 2: random with gaps
   task automatic send_beats(input int nb, input logic [10:0] base, input int mode);
      logic [127:0] w = '0;
      logic [10:0]  a = base;
      int n;
      for (int i = 0; i < nb; i++) begin
         if (mode == 2) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         in_data  = (mode == 0) ? 32'h11111111 * (i % 4 + 1) : $urandom;
         in_valid = 1'b1;
         n = 0;
         while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
         chk("beat_timeout", n < 200, 1);
         w[(i % 4) * 32 +: 32] = in_data;
         if (i % 4 == 3) begin
            ea.push_back(a);
            ed.push_back(w);
            a++;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic chk_reset_state();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_ur_we", ur_we, 0);
      chk("rst_ur_addr", ur_addr, 0);
      chk("rst_ur_wdata", ur_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      @(posedge clk); #1;
      chk_reset_state();
      rst = 1'b0;
      @(posedge clk); #1;

      w0 = writes; d0 = dones;
      send_cmd(11'd0, 12'd1);
      send_beats(4, 11'd0, 0);
      chk("t1_ur_we", ur_we, 1);
      chk("t1_wdata_literal", ur_wdata, 128'h44444444_33333333_22222222_11111111);
      @(posedge clk); #1;
      chk("t1_busy_after", busy, 0);
      chk("t1_writes", writes - w0, 1);
      chk("t1_dones", dones - d0, 1);
      chk("t1_done_with_we", done_we, 1);
      chk("t1_done_err", done_err, 0);

      w0 = writes; d0 = dones; i0 = wcyc.size();
      send_cmd(11'd2046, 12'd4);
      send_beats(16, 11'd2046, 1);
      @(posedge clk); #1;
      chk("t2_writes", writes - w0, 4);
      chk("t2_dones", dones - d0, 1);
      if (wcyc.size() >= i0 + 4)
         for (int k = 1; k < 4; k++) chk("t2_write_gap", wcyc[i0 + k] - wcyc[i0 + k - 1], 4);

      w0 = writes; d0 = dones; a0 = accepts;
      send_cmd(11'd300, 12'd2);
      cmd_valid = 1'b1; cmd_base = 11'd100; cmd_len = 12'd0;
      send_beats(8, 11'd300, 2);
      chk("t3_in_ready_after_last", in_ready, 0);
      chk("t3_done", done, 1);
      chk("t3_cmd_ready_busy", cmd_ready, 0);
      @(posedge clk); #1;
      chk("t3_cmd_ready_idle", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("t3_held_cmd_done", done, 1);
      chk("t3_held_cmd_err", err, 0);
      @(posedge clk); #1;
      chk("t3_writes", writes - w0, 2);
      chk("t3_accepts", accepts - a0, 2);
      chk("t3_dones", dones - d0, 2);

      w0 = writes;
      send_cmd(11'd7, 12'd0);
      chk("t4_len0_done", done, 1);
      chk("t4_len0_err", err, 0);
      chk("t4_len0_we", ur_we, 0);
      @(posedge clk); #1;
      send_cmd(11'd7, 12'd2049);
      chk("t4_long_done", done, 1);
      chk("t4_long_err", err, 1);
      chk("t4_long_we", ur_we, 0);
      @(posedge clk); #1;
      chk("t4_writes", writes - w0, 0);

      w0 = writes;
      send_cmd(11'd9, 12'd1);
      send_beats(2, 11'd9, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_state();
      rst = 1'b0;
      @(posedge clk); #1;
      chk("t5_no_write_after_rst", writes - w0, 0);
      send_cmd(11'd5, 12'd1);
      send_beats(4, 11'd5, 1);
      @(posedge clk); #1;
      chk("t5_writes", writes - w0, 1);

`ifdef LDB_LOADER_ABORT_EN
      w0 = writes;
      send_cmd(11'd10, 12'd3);
      send_beats(6, 11'd10, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("t6_abort_done", done, 1);
      chk("t6_abort_err", err, 1);
      chk("t6_abort_we", ur_we, 0);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("t6_idle_abort_busy", busy, 0);
      chk("t6_idle_abort_done", done, 0);
      chk("t6_writes", writes - w0, 1);
`endif

      chk("sb_empty", ea.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
